// File: rtl/kyber_dout_reorder.sv
// Output reorder buffer for the single-PE Kyber multiplier: captures the BRAM-interleaved
// INTT burst (0,128,1,129,...) and replays it in natural order 0..255 on a valid/ready port.
module kyber_dout_reorder #(
    parameter int DW     = 12,
    parameter int RD_LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          read_a,
    input  logic [DW-1:0] core_dout,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic [2:0]    o_dbg_state
);

    // Handshake: a word moves when m_valid && m_ready at a rising edge; once m_valid is
    // raised, m_data/m_last hold and m_valid stays high until that transfer happens.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2:0]      r_wait_cnt;
    logic [7:0]      r_cap_cnt;
    logic [8:0]      r_rd_ptr;

    logic [DW-1:0]   r_mem [0:255];
    logic [DW-1:0]   r_ram_q;
    logic            r_ram_vld;
    logic            r_ram_last;

    logic [DW-1:0]   r_out_data;
    logic            r_out_vld;
    logic            r_out_last;
    logic [DW-1:0]   r_skid_data;
    logic            r_skid_vld;
    logic            r_skid_last;
    logic            r_done;

    logic            w_fire;
    logic            w_last_fire;
    logic [1:0]      w_occ;
    logic            w_rd_en;

    assign w_fire      = r_out_vld & m_ready;
    assign w_last_fire = w_fire & r_out_last;
    // Words held or in flight after this edge; a read may only issue if its data will fit.
    assign w_occ       = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_ram_vld) - 2'(w_fire);
    assign w_rd_en     = (r_state == S_DRAIN) && !r_rd_ptr[8] && (w_occ <= 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_REQ;
            S_REQ:     w_next = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (r_wait_cnt == 3'd1) w_next = S_CAPTURE;
            S_CAPTURE: if (r_cap_cnt == 8'd255) w_next = S_DRAIN;
            S_DRAIN:   if (w_last_fire) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        read_a      = (r_state == S_REQ);
        busy        = (r_state != S_IDLE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_cap_cnt  <= '0;
            r_rd_ptr   <= '0;
            r_done     <= 1'b0;
        end else begin
            if (r_state == S_REQ) begin
                r_wait_cnt <= 3'(RD_LAT - 1);
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (r_state == S_CAPTURE) begin
                r_cap_cnt <= r_cap_cnt + 8'd1;
            end else begin
                r_cap_cnt <= '0;
            end
            if (r_state != S_DRAIN) begin
                r_rd_ptr <= '0;
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 9'd1;
            end
            r_done <= (r_state == S_DRAIN) && w_last_fire;
        end
    end

    // Burst position c lands at natural index c[0]*128 + c[7:1].
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            r_mem[{r_cap_cnt[0], r_cap_cnt[7:1]}] <= core_dout;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr[7:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_vld  <= 1'b0;
            r_ram_last <= 1'b0;
        end else begin
            r_ram_vld  <= w_rd_en;
            r_ram_last <= w_rd_en && (r_rd_ptr == 9'd255);
        end
    end

    // Output register fed from the skid first so order is preserved; the skid only fills
    // while the output register is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
        end else if (r_ram_vld) begin
            if (!r_out_vld || w_fire) begin
                r_out_vld <= 1'b1;
                if (r_skid_vld) begin
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_skid_data <= r_ram_q;
                    r_skid_last <= r_ram_last;
                end else begin
                    r_out_data <= r_ram_q;
                    r_out_last <= r_ram_last;
                end
            end else begin
                r_skid_data <= r_ram_q;
                r_skid_last <= r_ram_last;
                r_skid_vld  <= 1'b1;
            end
        end else if (w_fire) begin
            if (r_skid_vld) begin
                r_out_data <= r_skid_data;
                r_out_last <= r_skid_last;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

    assign m_data  = r_out_data;
    assign m_valid = r_out_vld;
    assign m_last  = r_out_last;
    assign done    = r_done;

endmodule

// File: tb/tb_kyber_dout_reorder.sv
// Bench for kyber_dout_reorder: three instances (RD_LAT 3, 1, 7) share start/m_ready/reset,
// each with its own interleaving core model and natural-order expected queue.
module tb_kyber_dout_reorder;
  localparam int DW = 12;

  typedef struct {
    logic [DW-1:0] seed;
    int            rdy_mode;
    bit            ign_starts;
    bit            tchk;
    int            exp_first_ofs;
    int            exp_done_ofs;
  } run_vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b1;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            t_start = 0;
  logic [DW-1:0] cur_seed = '0;
  int            rdy_mode = 0;
  bit            timing_chk = 1'b0;
  bit            b2b_chk = 1'b0;
  int            exp_first_ofs = 258;
  int            exp_done_ofs = 514;
  int            runs_done [3] = '{0, 0, 0};
  int            run_target = 0;
  logic [5:0]    rdy_pat = 6'b011001;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int lat, input bit ok, input string name, input int got, input int want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL L%0d %s: got %0d (0x%0h) want %0d (0x%0h) at cyc %0d", lat, name, got, got, want, want, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 7);
    logic          read_a, m_valid, m_last, busy, done;
    logic [DW-1:0] core_dout = '0;
    logic [DW-1:0] m_data;
    logic [2:0]    dbg_state;
    logic [DW:0]   exp_q[$];
    int            ra_cnt = 0, xfers = 0, first_neg = 0, last_neg = 0, done_neg = 0, ra_neg = 0;
    bit            burst_on = 1'b0, armed = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] bseed = '0, prev_data = '0;
    logic          prev_last = 1'b0;

    kyber_dout_reorder #(.DW(DW), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .read_a     (read_a),
      .core_dout  (core_dout),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done),
      .o_dbg_state(dbg_state)
    );

    // core model + scoreboard, sampled mid-cycle
    always @(negedge clk) begin
      int pos;
      logic [DW:0] e;
      if (reset) begin
        exp_q.delete();
        burst_on = 1'b0; armed = 1'b0; prev_stall = 1'b0;
        xfers = 0; ra_cnt = 0;
        core_dout = DW'($urandom);
      end else begin
        if (read_a) begin
          ra_cnt++;
          ra_neg = cyc;
          bseed = cur_seed;
          burst_on = 1'b1;
          if (armed) begin
            chk(LAT, ra_neg == done_neg + 1, "b2b_start", ra_neg - done_neg, 1);
            armed = 1'b0;
          end else if (timing_chk) begin
            chk(LAT, ra_neg == t_start, "read_a_time", ra_neg - t_start, 0);
          end
          for (int n = 0; n < 256; n++) exp_q.push_back({(n == 255), DW'(n) ^ bseed});
        end
        pos = cyc - ra_neg - LAT;
        if (burst_on && pos >= 0 && pos < 256) core_dout = DW'((pos % 2) * 128 + pos / 2) ^ bseed;
        else core_dout = DW'($urandom);

        if (prev_stall) begin
          chk(LAT, m_valid && m_data == prev_data && m_last == prev_last, "stall_hold",
              {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
        end
        if (!m_valid) chk(LAT, !m_last, "last_without_valid", m_last, 0);
        if (m_valid && m_ready) begin
          xfers++;
          if (xfers == 1) first_neg = cyc;
          last_neg = cyc;
          chk(LAT, busy, "busy_in_drain", busy, 1);
          chk(LAT, exp_q.size() != 0, "xfer_expected", exp_q.size(), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(LAT, {m_last, m_data} == e, "xfer_data", {m_last, m_data}, e);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;

        if (done) begin
          chk(LAT, xfers == 256, "xfer_count", xfers, 256);
          chk(LAT, exp_q.size() == 0, "queue_left", exp_q.size(), 0);
          chk(LAT, ra_cnt == 1, "read_a_pulses", ra_cnt, 1);
          chk(LAT, cyc == last_neg + 1, "done_after_last", cyc - last_neg, 1);
          chk(LAT, !busy, "busy_at_done", busy, 0);
          if (timing_chk) begin
            chk(LAT, first_neg == t_start + exp_first_ofs + LAT, "first_xfer_time",
                first_neg - t_start, exp_first_ofs + LAT);
            chk(LAT, cyc == t_start + exp_done_ofs + LAT, "done_time", cyc - t_start, exp_done_ofs + LAT);
          end
          if (b2b_chk) armed = 1'b1;
          runs_done[g]++;
          done_neg = cyc;
          xfers = 0;
          ra_cnt = 0;
        end
      end
    end
  end

  // m_ready driver: 0 = always ready, 1 = pattern 1,0,0,1,1,0, else random
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: begin m_ready = rdy_pat[ph % 6]; ph++; end
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // driver tasks
  task automatic start_at(input int e);
    while (cyc < e - 1) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_runs(input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (runs_done[0] >= target && runs_done[1] >= target && runs_done[2] >= target) break;
    end
    chk(0, k < budget, "run_timeout", runs_done[0] + 1000 * runs_done[1] + 1000000 * runs_done[2], target);
  endtask

  task automatic idle_all();
    chk(3, {g_dut[0].read_a, g_dut[0].m_valid, g_dut[0].m_last, g_dut[0].busy, g_dut[0].done, g_dut[0].m_data} == '0,
        "reset_outputs", {g_dut[0].read_a, g_dut[0].m_valid, g_dut[0].m_last, g_dut[0].busy, g_dut[0].done, g_dut[0].m_data}, 0);
    chk(1, {g_dut[1].read_a, g_dut[1].m_valid, g_dut[1].m_last, g_dut[1].busy, g_dut[1].done, g_dut[1].m_data} == '0,
        "reset_outputs", {g_dut[1].read_a, g_dut[1].m_valid, g_dut[1].m_last, g_dut[1].busy, g_dut[1].done, g_dut[1].m_data}, 0);
    chk(7, {g_dut[2].read_a, g_dut[2].m_valid, g_dut[2].m_last, g_dut[2].busy, g_dut[2].done, g_dut[2].m_data} == '0,
        "reset_outputs", {g_dut[2].read_a, g_dut[2].m_valid, g_dut[2].m_last, g_dut[2].busy, g_dut[2].done, g_dut[2].m_data}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); idle_all();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); idle_all();
  endtask

  task automatic run_one(input run_vec_t v);
    cur_seed = v.seed;
    rdy_mode = v.rdy_mode;
    timing_chk = v.tchk;
    exp_first_ofs = v.exp_first_ofs;
    exp_done_ofs = v.exp_done_ofs;
    start_at(cyc + 2);
    t_start = cyc;
    if (v.ign_starts) begin
      start_at(t_start + 1);    // REQ
      start_at(t_start + 2);    // WAIT (CAPTURE for RD_LAT=1)
      start_at(t_start + 60);   // CAPTURE
      start_at(t_start + 300);  // DRAIN
    end
    run_target++;
    wait_runs(run_target, 2500);
  endtask

  initial begin
    run_vec_t vec [4];
    vec[0] = '{12'h000, 0, 1'b0, 1'b1, 258, 514};
    vec[1] = '{12'h5A3, 1, 1'b0, 1'b0, 258, 514};
    vec[2] = '{DW'($urandom), 2, 1'b1, 1'b0, 258, 514};
    vec[3] = '{12'hFFF, 0, 1'b1, 1'b1, 258, 514};

    do_reset();
    for (int i = 0; i < 4; i++) run_one(vec[i]);

    // back-to-back: start held high, accepted on each instance's done cycle
    b2b_chk = 1'b1;
    cur_seed = 12'h9E1;
    rdy_mode = 0;
    timing_chk = 1'b1;
    exp_first_ofs = 258;
    exp_done_ofs = 514;
    start_at(cyc + 2);
    t_start = cyc;
    start = 1'b1;
    run_target++;
    wait_runs(run_target, 2500);
    @(posedge clk); #1;
    start = 1'b0;
    timing_chk = 1'b0;
    b2b_chk = 1'b0;
    run_target++;
    wait_runs(run_target, 2500);

    // reset after 100 captured words on the RD_LAT=3 instance, then a clean run
    cur_seed = 12'h3C7;
    rdy_mode = 0;
    timing_chk = 1'b0;
    start_at(cyc + 2);
    t_start = cyc;
    while (cyc < t_start + 103) begin @(posedge clk); #1; end
    do_reset();
    run_one(vec[0]);
    run_one(vec[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
